data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised RISC-V data memory for the multicycle and pipelined cores, replacing the fixed 16K-word, word-only, combinational-read memory. It supports the full RV32I load/store size set (byte, half, word, signed and unsigned), detects misaligned and illegal accesses, and adds a configurable wait-state latency with a req/ready handshake. After reset it runs an optional zero-fill sequence. It sits between the core's MEM stage / LSU and backing storage.

## Interface
- DEPTH, 16384: memory size in 32-bit words, power of two, ≥ 4.
- LATENCY, 1: wait states between request acceptance and response, 0..7.
- CLEAR_ON_RESET, 1: when 1, zero-fill all words after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request, sampled only when accepting.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended to 32 bits; held between responses.
- ready  out  1  one-cycle response strobe.
- fault  out  1  valid with ready: access was misaligned or illegal.
- busy  out  1  zero-fill in progress; requests are dropped.

## Operation
- States: CLEAR, IDLE, WAIT, RESP.
- Reset (async): state = CLEAR if CLEAR_ON_RESET, else IDLE. rdata = 0, ready = 0, fault = 0, busy = CLEAR_ON_RESET, fill counter = 0, wait counter = 0.
- CLEAR: write 0 to word[counter] once per cycle, counter 0..DEPTH-1. Go to IDLE after the write of DEPTH-1. busy = 1 throughout; req is ignored.
- Request acceptance: in IDLE or RESP, if req = 1, capture we, funct3, addr and wdata, then load the wait counter with LATENCY.
  - LATENCY = 0: go to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 0. req is ignored.
- RESP: ready = 1 for exactly one cycle. Without a new req, go to IDLE.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4·DEPTH.
- Fault conditions:
  - H/HU with addr[0] ≠ 0.
  - W with addr[1:0] ≠ 0.
  - Illegal funct3.
  - On fault: no memory write, rdata = 0, fault = 1 with ready.
- Stores, committed on the edge entering RESP:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes addr[1]·2 +{0,1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Other lanes are unchanged.
- Loads: extract the byte/half at the same lanes and sign-extend (B, H) or zero-extend (BU, HU). rdata updates on the edge entering RESP.
- Store response: rdata = 0, fault as above.
- Reset during WAIT/RESP: the pending access is discarded (no write), then CLEAR restarts from word 0.

## Timing
- Request accepted in cycle N → ready high in cycle N+1+LATENCY.
- Store visible to a load accepted in any cycle ≥ that ready cycle.
- Maximum throughput: one access per LATENCY+1 cycles, using acceptance in RESP.
- busy high for exactly DEPTH cycles after reset deassertion, then IDLE.
- No combinational path from inputs to outputs.

## Structure
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {CLEAR, IDLE, WAIT, RESP}.
- Sub-module dmem_lane_align (combinational) produces:
  - from (funct3, addr[1:0], wdata): the store byte-mask, the lane-shifted store data and the fault flag;
  - from (funct3, addr[1:0], raw word): the extended load data.
- Top module holds the storage array, the FSM and both counters.

## Test plan
- DEPTH = 16, CLEAR_ON_RESET = 1, memory preloaded with 0xFFFFFFFF, reset released → busy high for 16 cycles, then LW at 0x0..0x3C all return 0x00000000.
- LATENCY = 1: SW 0xDEADBEEF @0x8, then LW @0x8 → ready 2 cycles after each acceptance, rdata = 0xDEADBEEF, fault = 0.
- SB wdata = 0x000000A5 @0x9, then:
  - LW @0x8 → 0xDEADA5EF;
  - LB @0x9 → 0xFFFFFFA5;
  - LBU @0x9 → 0x000000A5;
  - LH @0xA → 0xFFFFDEAD.
- LH @0x3, SW @0xA, and funct3 = 011 @0x8 → each gives fault = 1, rdata = 0; word @0x8 unchanged.
- LW @0x48 with DEPTH = 16 → returns the word at 0x8 (aliasing); back-to-back req held high with LATENCY = 0 → ready every cycle.
- LATENCY = 3: SW 0x12345678 @0x4, rst pulsed in the 2nd WAIT cycle → outputs zero immediately, busy = 1, word @0x4 reads 0 after the fill.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: RV32I load/store size codes and FSM states.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I accesses: store mask/data, load extension and access fault.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic        fault,
    output logic [31:0] rdata_ext
);
    logic [7:0]  rb;
    logic [15:0] rh;

    always_comb begin
        rb        = raw[{off, 3'b000} +: 8];
        rh        = off[1] ? raw[31:16] : raw[15:0];
        be        = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
        fault     = 1'b0;
        // Store data is replicated across lanes; the byte mask picks the live ones.
        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = (funct3 == F3_B) ? {{24{rb[7]}}, rb} : {24'b0, rb};
            end
            F3_H, F3_HU: begin
                fault     = off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = (funct3 == F3_H) ? {{16{rh[15]}}, rh} : {16'b0, rh};
            end
            F3_W: begin
                fault     = (off != 2'b00);
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = raw;
            end
            default: fault = 1'b1;
        endcase
        if (fault) begin
            be        = 4'b0000;
            rdata_ext = '0;
        end
    end
endmodule

// File: rtl/data_memory_sized.sv
// Parametrised RV32I data memory with byte/half/word access, wait states, req/ready
// handshake and an optional post-reset zero fill.
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 16384,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic        busy
);
    localparam int            AW        = $clog2(DEPTH);
    localparam logic [2:0]    LAT       = 3'(LATENCY);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
    localparam state_t        RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [31:0] mem [DEPTH];

    state_t        state, state_nx;
    logic [AW-1:0] fcnt;
    logic [2:0]    wcnt;
    logic          cap_we;
    logic [2:0]    cap_f3;
    logic [31:0]   cap_addr, cap_wdata;

    logic          op_we;
    logic [2:0]    op_f3;
    logic [31:0]   op_addr, op_wdata;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wsh, rext;
    logic          flt, accept, enter_resp;
    logic          unused_addr;

    assign accept     = req && (state == IDLE || state == RESP);
    assign enter_resp = (state_nx == RESP);
    assign busy       = (state == CLEAR);
    assign ready      = (state == RESP);

    // With no wait states the access completes on the accepting edge, so use live inputs.
    assign op_we    = (LATENCY == 0) ? we     : cap_we;
    assign op_f3    = (LATENCY == 0) ? funct3 : cap_f3;
    assign op_addr  = (LATENCY == 0) ? addr   : cap_addr;
    assign op_wdata = (LATENCY == 0) ? wdata  : cap_wdata;

    assign idx         = op_addr[AW+1:2];
    assign unused_addr = ^op_addr[31:AW+2];

    dmem_lane_align u_align (
        .funct3    (op_f3),
        .off       (op_addr[1:0]),
        .wdata     (op_wdata),
        .raw       (mem[idx]),
        .be        (be),
        .wdata_sh  (wsh),
        .fault     (flt),
        .rdata_ext (rext)
    );

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:      if (fcnt == LAST) state_nx = IDLE;
            IDLE, RESP: state_nx = req ? ((LAT == 3'd0) ? RESP : WAIT) : IDLE;
            WAIT:       if (wcnt == 3'd1) state_nx = RESP;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RST_STATE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt      <= '0;
            wcnt      <= '0;
            cap_we    <= 1'b0;
            cap_f3    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
            fault     <= 1'b0;
        end else begin
            if (state == CLEAR) fcnt <= fcnt + AW'(1);
            if (accept) begin
                wcnt      <= LAT;
                cap_we    <= we;
                cap_f3    <= funct3;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end else if (state == WAIT) begin
                wcnt <= wcnt - 3'd1;
            end
            if (enter_resp) begin
                rdata <= op_we ? '0 : rext;
                fault <= flt;
            end else begin
                fault <= 1'b0;
            end
        end
    end

    // Storage has no reset; an async reset redirects the FSM so a pending store never lands.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[fcnt] <= '0;
        end else if (enter_resp && op_we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: three small instances at LATENCY 1, 0 and 3.
module tb_data_memory_sized;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rst3, req1, req0, req3, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata1, rdata0, rdata3;
    logic        ready1, ready0, ready3, fault1, fault0, fault3, busy1, busy0, busy3;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    data_memory_sized #(.DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_l1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .fault(fault1), .busy(busy1));
    data_memory_sized #(.DEPTH(16), .LATENCY(0), .CLEAR_ON_RESET(1'b1)) u_l0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .fault(fault0), .busy(busy0));
    data_memory_sized #(.DEPTH(16), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_l3 (
        .clk(clk), .rst(rst3), .req(req3), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .fault(fault3), .busy(busy3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on instance 1 or 3; checks response latency, rdata and fault.
    task automatic acc(input int sel, input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_f,
                       input string tag);
        int n;
        @(negedge clk);
        we = w; funct3 = f; addr = a; wdata = d;
        if (sel == 3) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0; req3 = 1'b0;
        n = 0;
        while (!(sel == 3 ? ready3 : ready1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, " latency"}, 32'(n), (sel == 3) ? 32'd3 : 32'd1);
        chk({tag, " rdata"}, (sel == 3) ? rdata3 : rdata1, exp_rd);
        chk({tag, " fault"}, 32'((sel == 3) ? fault3 : fault1), 32'(exp_f));
    endtask

    task automatic fill_wait(input int sel, input string tag);
        int n;
        n = 0;
        while ((sel == 3 ? busy3 : busy1) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1; req1 = 1'b0; req0 = 1'b0; req3 = 1'b0;
        we = 1'b0; funct3 = F3_W; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready1), 32'd0);
        chk("reset fault", 32'(fault1), 32'd0);
        chk("reset rdata", rdata1, 32'd0);
        chk("reset busy", 32'(busy1), 32'd1);
        @(negedge clk); rst = 1'b0; rst3 = 1'b0;
        fill_wait(1, "first fill cycles");

        // Dirty every word, then reset and confirm the fill wipes it.
        for (int i = 0; i < 16; i++) acc(1, 1'b1, F3_W, 32'(i * 4), 32'hFFFF_FFFF, 32'd0, 1'b0, "preload");
        acc(1, 1'b0, F3_W, 32'h3C, 32'd0, 32'hFFFF_FFFF, 1'b0, "preload readback");
        @(negedge clk); rst = 1'b1; #1;
        chk("reset busy again", 32'(busy1), 32'd1);
        @(negedge clk); rst = 1'b0;
        fill_wait(1, "refill cycles");
        for (int i = 0; i < 16; i++) acc(1, 1'b0, F3_W, 32'(i * 4), 32'd0, 32'd0, 1'b0, "zeroed word");

        acc(1, 1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0, "SW 8");
        acc(1, 1'b0, F3_W, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0, "LW 8");
        @(posedge clk); #1;
        chk("ready one cycle", 32'(ready1), 32'd0);

        acc(1, 1'b1, F3_B,  32'h9, 32'h0000_00A5, 32'd0, 1'b0, "SB 9");
        acc(1, 1'b0, F3_W,  32'h8, 32'd0, 32'hDEAD_A5EF, 1'b0, "LW 8 after SB");
        acc(1, 1'b0, F3_B,  32'h9, 32'd0, 32'hFFFF_FFA5, 1'b0, "LB 9");
        acc(1, 1'b0, F3_BU, 32'h9, 32'd0, 32'h0000_00A5, 1'b0, "LBU 9");
        acc(1, 1'b0, F3_H,  32'hA, 32'd0, 32'hFFFF_DEAD, 1'b0, "LH A");
        acc(1, 1'b0, F3_HU, 32'hA, 32'd0, 32'h0000_DEAD, 1'b0, "LHU A");
        acc(1, 1'b0, F3_B,  32'h8, 32'd0, 32'hFFFF_FFEF, 1'b0, "LB 8");

        acc(1, 1'b0, F3_H,   32'h3, 32'd0, 32'd0, 1'b1, "LH 3 misaligned");
        acc(1, 1'b1, F3_W,   32'hA, 32'h1111_1111, 32'd0, 1'b1, "SW A misaligned");
        acc(1, 1'b0, 3'b011, 32'h8, 32'd0, 32'd0, 1'b1, "funct3 011");
        acc(1, 1'b1, 3'b111, 32'h8, 32'h2222_2222, 32'd0, 1'b1, "store funct3 111");
        acc(1, 1'b1, F3_H,   32'h9, 32'h3333_3333, 32'd0, 1'b1, "SH 9 misaligned");
        acc(1, 1'b0, F3_W,   32'h8, 32'd0, 32'hDEAD_A5EF, 1'b0, "LW 8 after faults");

        acc(1, 1'b1, F3_H,  32'hA, 32'hBEEF_7F01, 32'd0, 1'b0, "SH A");
        acc(1, 1'b0, F3_H,  32'hA, 32'd0, 32'h0000_7F01, 1'b0, "LH A after SH");
        acc(1, 1'b0, F3_W,  32'h48, 32'd0, 32'h7F01_A5EF, 1'b0, "LW 48 alias");
        acc(1, 1'b1, F3_W,  32'h4C, 32'h0BAD_CAFE, 32'd0, 1'b0, "SW 4C alias");
        acc(1, 1'b0, F3_W,  32'hC, 32'd0, 32'h0BAD_CAFE, 1'b0, "LW C alias");

        // Zero-latency instance with req held high: one response per cycle.
        @(negedge clk); we = 1'b1; funct3 = F3_W; addr = 32'h10; wdata = 32'hCAFE_F00D; req0 = 1'b1;
        @(posedge clk); #1;
        chk("b2b SW ready", 32'(ready0), 32'd1);
        chk("b2b SW rdata", rdata0, 32'd0);
        @(negedge clk); we = 1'b0;
        @(posedge clk); #1;
        chk("b2b LW ready", 32'(ready0), 32'd1);
        chk("b2b LW rdata", rdata0, 32'hCAFE_F00D);
        @(negedge clk); funct3 = F3_BU; addr = 32'h13;
        @(posedge clk); #1;
        chk("b2b LBU ready", 32'(ready0), 32'd1);
        chk("b2b LBU rdata", rdata0, 32'h0000_00CA);
        @(negedge clk); funct3 = F3_H; addr = 32'h11;
        @(posedge clk); #1;
        chk("b2b LH ready", 32'(ready0), 32'd1);
        chk("b2b LH fault", 32'(fault0), 32'd1);
        chk("b2b LH rdata", rdata0, 32'd0);
        @(negedge clk); req0 = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle ready", 32'(ready0), 32'd0);

        // Three wait states; reset lands in the second WAIT cycle of a store.
        acc(3, 1'b1, F3_W, 32'h0, 32'hA5A5_A5A5, 32'd0, 1'b0, "L3 SW 0");
        acc(3, 1'b0, F3_W, 32'h0, 32'd0, 32'hA5A5_A5A5, 1'b0, "L3 LW 0");
        @(negedge clk); we = 1'b1; funct3 = F3_W; addr = 32'h4; wdata = 32'h1234_5678; req3 = 1'b1;
        @(posedge clk); #1; req3 = 1'b0;
        @(posedge clk); #1;
        chk("L3 still waiting", 32'(ready3), 32'd0);
        rst3 = 1'b1; #1;
        chk("L3 rst rdata", rdata3, 32'd0);
        chk("L3 rst ready", 32'(ready3), 32'd0);
        chk("L3 rst fault", 32'(fault3), 32'd0);
        chk("L3 rst busy", 32'(busy3), 32'd1);
        @(negedge clk); rst3 = 1'b0;
        fill_wait(3, "L3 fill cycles");
        acc(3, 1'b0, F3_W, 32'h4, 32'd0, 32'd0, 1'b0, "L3 LW 4 discarded");
        acc(3, 1'b0, F3_W, 32'h0, 32'd0, 32'd0, 1'b0, "L3 LW 0 cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
